// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Brief    : Shared constants, state encoding and helpers for the branch
//             predictor (entry layout widths, counter constants).
//  Revision : 1.0 - initial tagged BTB with direction counters
// ============================================================================
package bp_pkg;

   // Stored branch target width
   localparam int unsigned TGT_W   = 32;
   // Valid flag width
   localparam int unsigned VALID_W = 1;

   // Predictor operating state: table sweep after reset, then normal run
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_e;

   // Saturated (strongly taken) counter value for a counter of width w
   function automatic int unsigned ctr_max(input int unsigned w);
      return (1 << w) - 1;
   endfunction

   // Weakly-taken counter value used on allocation
   function automatic int unsigned ctr_weak(input int unsigned w);
      return 1 << (w - 1);
   endfunction

   // Packed entry width: {valid, tag, target, ctr}
   function automatic int unsigned entry_w(input int unsigned tag_w,
                                           input int unsigned ctr_w);
      return VALID_W + tag_w + TGT_W + ctr_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
// ============================================================================
//  Module   : bp_table
//  Brief    : Predictor storage. One write port, one synchronous read port
//             with write-first bypass (lookup), and one combinational read
//             port used by the update read-modify-write.
//  Revision : 1.0 - initial
// ============================================================================
module bp_table
   import bp_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = VALID_W + 8 + TGT_W + 2
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata,
   input  logic [ADDR_W-1:0] i_aaddr,
   output logic [DATA_W-1:0] o_adata
);

   localparam int unsigned c_depth = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [0:c_depth-1];
   logic [DATA_W-1:0] r_rdata;

   // Array write
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered lookup read; a same-cycle write to the same entry is forwarded
   always_ff @(posedge clk) begin
      if (i_we && (i_waddr == i_raddr)) begin
         r_rdata <= i_wdata;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
   assign o_adata = r_mem[i_aaddr];

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Brief    : Tagged BTB with per-entry saturating direction counters.
//             Looked up by the IF PC (result registered into ID), trained by
//             every resolved control instruction from WB. The table is
//             cleared by a one-entry-per-cycle sweep after reset.
//  Revision : 1.0 - replaces untagged 1-bit valid+target BTB
// ============================================================================
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned IDX_W = 10,
   parameter int unsigned TAG_W = 8,
   parameter int unsigned CTR_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lk_pc,
   output logic        lk_hit,
   output logic        lk_taken,
   output logic [31:0] lk_target,
   input  logic        up_en,
   input  logic [31:0] up_pc,
   input  logic        up_taken,
   input  logic [31:0] up_target,
   output logic        init_done
);

   // Entry layout {valid, tag, target, ctr}
   localparam int unsigned c_ent_w   = entry_w(TAG_W, CTR_W);
   localparam int unsigned c_valid_b = c_ent_w - 1;
   localparam int unsigned c_tag_lsb = CTR_W + TGT_W;
   localparam int unsigned c_tgt_lsb = CTR_W;
   localparam int unsigned c_pc_hi   = 2 + IDX_W + TAG_W;

   localparam logic [CTR_W-1:0] c_ctr_max  = CTR_W'(ctr_max(CTR_W));
   localparam logic [CTR_W-1:0] c_ctr_weak = CTR_W'(ctr_weak(CTR_W));

   // ---------------------------------------------------------------- FSM
   bp_state_e         r_state;
   bp_state_e         w_state_nxt;
   logic [IDX_W-1:0]  r_sweep_idx;
   logic [IDX_W-1:0]  w_sweep_nxt;
   logic              w_sweep_last;

   assign w_sweep_last = &r_sweep_idx;

   // State and sweep index registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_sweep_idx <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_idx <= w_sweep_nxt;
      end
   end

   // Next state: walk every index once, then enter normal operation
   always_comb begin
      w_state_nxt = r_state;
      w_sweep_nxt = r_sweep_idx;
      case (r_state)
         ST_INIT: begin
            if (w_sweep_last) begin
               w_state_nxt = ST_RUN;
               w_sweep_nxt = '0;
            end else begin
               w_sweep_nxt = r_sweep_idx + IDX_W'(1);
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_sweep_nxt = '0;
         end
      endcase
   end

   assign init_done = (r_state == ST_RUN);

   // ---------------------------------------------------------- update path
   logic [IDX_W-1:0]   w_up_idx;
   logic [TAG_W-1:0]   w_up_tag;
   logic [c_ent_w-1:0] w_up_rd;
   logic               w_up_hit;
   logic [CTR_W-1:0]   w_up_ctr;
   logic [CTR_W-1:0]   w_ctr_new;
   logic [TGT_W-1:0]   w_up_old_tgt;

   logic               w_we;
   logic [IDX_W-1:0]   w_waddr;
   logic [c_ent_w-1:0] w_wdata;

   assign w_up_idx     = up_pc[2 +: IDX_W];
   assign w_up_tag     = up_pc[2 + IDX_W +: TAG_W];
   assign w_up_hit     = w_up_rd[c_valid_b] && (w_up_rd[c_tag_lsb +: TAG_W] == w_up_tag);
   assign w_up_ctr     = w_up_rd[CTR_W-1:0];
   assign w_up_old_tgt = w_up_rd[c_tgt_lsb +: TGT_W];

   // Write port: sweep clears entries in INIT; in RUN the resolved branch
   // trains a hitting entry or allocates on a taken miss
   always_comb begin
      w_we      = 1'b0;
      w_waddr   = r_sweep_idx;
      w_wdata   = '0;
      w_ctr_new = w_up_ctr;
      if (!rst) begin
         if (r_state == ST_INIT) begin
            w_we = 1'b1;
         end else if (up_en) begin
            w_waddr = w_up_idx;
            if (w_up_hit) begin
               w_we = 1'b1;
               if (up_taken) begin
                  w_ctr_new = (w_up_ctr == c_ctr_max) ? w_up_ctr : w_up_ctr + CTR_W'(1);
                  w_wdata   = {1'b1, w_up_tag, up_target, w_ctr_new};
               end else begin
                  w_ctr_new = (w_up_ctr == '0) ? w_up_ctr : w_up_ctr - CTR_W'(1);
                  w_wdata   = {1'b1, w_up_tag, w_up_old_tgt, w_ctr_new};
               end
            end else if (up_taken) begin
               w_we    = 1'b1;
               w_wdata = {1'b1, w_up_tag, up_target, c_ctr_weak};
            end
         end
      end
   end

   // ---------------------------------------------------------- lookup path
   logic [IDX_W-1:0]   w_lk_idx;
   logic [TAG_W-1:0]   w_lk_tag;
   logic [TAG_W-1:0]   r_lk_tag;
   logic               r_lk_en;
   logic [c_ent_w-1:0] w_lk_rd;
   logic               w_lk_hit;

   assign w_lk_idx = lk_pc[2 +: IDX_W];
   assign w_lk_tag = lk_pc[2 + IDX_W +: TAG_W];

   // Capture the lookup tag and whether the table was live when sampled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lk_en  <= 1'b0;
         r_lk_tag <= '0;
      end else begin
         r_lk_en  <= (r_state == ST_RUN);
         r_lk_tag <= w_lk_tag;
      end
   end

   assign w_lk_hit  = r_lk_en && w_lk_rd[c_valid_b] && (w_lk_rd[c_tag_lsb +: TAG_W] == r_lk_tag);
   assign lk_hit    = w_lk_hit;
   assign lk_taken  = w_lk_hit && w_lk_rd[CTR_W-1];
   assign lk_target = w_lk_hit ? w_lk_rd[c_tgt_lsb +: TGT_W] : '0;

   bp_table #(
      .ADDR_W (IDX_W),
      .DATA_W (c_ent_w)
   ) u_table (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_lk_idx),
      .o_rdata (w_lk_rd),
      .i_aaddr (w_up_idx),
      .o_adata (w_up_rd)
   );

   // PC bits outside index/tag take no part in prediction
   logic w_unused_lo;
   logic w_unused_hi;
   assign w_unused_lo = ^{lk_pc[1:0], up_pc[1:0]};

   generate
      if (c_pc_hi < 32) begin : g_pc_hi_unused
         assign w_unused_hi = ^{lk_pc[31:c_pc_hi], up_pc[31:c_pc_hi]};
      end else begin : g_pc_hi_none
         assign w_unused_hi = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Brief    : Self-checking bench: directed scenarios plus random traffic,
//             expected lookups queued by a behavioural model and compared by
//             an independent monitor.
//  Revision : 1.0 - initial
// ============================================================================
module tb_branch_predictor;

   localparam int IDX_W = 4;
   localparam int TAG_W = 8;
   localparam int CTR_W = 2;
   localparam int DEPTH = 1 << IDX_W;
   localparam int CMAX  = (1 << CTR_W) - 1;
   localparam int CWEAK = 1 << (CTR_W - 1);

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lk_pc;
   logic        lk_hit;
   logic        lk_taken;
   logic [31:0] lk_target;
   logic        up_en;
   logic [31:0] up_pc;
   logic        up_taken;
   logic [31:0] up_target;
   logic        init_done;

   branch_predictor #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .CTR_W (CTR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .lk_pc     (lk_pc),
      .lk_hit    (lk_hit),
      .lk_taken  (lk_taken),
      .lk_target (lk_target),
      .up_en     (up_en),
      .up_pc     (up_pc),
      .up_taken  (up_taken),
      .up_target (up_target),
      .init_done (init_done)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          hit;
      bit          taken;
      logic [31:0] tgt;
      bit          done;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   started  = 0;

   // Reference table, one record per index
   bit          m_valid [DEPTH];
   int unsigned m_tag   [DEPTH];
   logic [31:0] m_tgt   [DEPTH];
   int          m_ctr   [DEPTH];
   int          init_left = 0;

   // Behavioural model: evaluated on every clock with the inputs the DUT sees
   initial begin
      forever begin
         @(posedge clk);
         begin
            exp_t        e;
            int unsigned ui, ut, li, lt;
            e = '{hit: 0, taken: 0, tgt: 32'h0, done: 0};
            if (rst) begin
               started   = 1;
               init_left = DEPTH;
               for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
               exp_q.push_back(e);
            end else if (started) begin
               if (init_left > 0) begin
                  init_left = init_left - 1;
                  e.done    = (init_left == 0);
               end else begin
                  e.done = 1;
                  if (up_en) begin
                     ui = (up_pc >> 2) % DEPTH;
                     ut = (up_pc >> (2 + IDX_W)) % (1 << TAG_W);
                     if (m_valid[ui] && m_tag[ui] == ut) begin
                        if (up_taken) begin
                           m_ctr[ui] = (m_ctr[ui] + 1 > CMAX) ? CMAX : m_ctr[ui] + 1;
                           m_tgt[ui] = up_target;
                        end else begin
                           m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
                        end
                     end else if (up_taken) begin
                        m_valid[ui] = 1;
                        m_tag[ui]   = ut;
                        m_tgt[ui]   = up_target;
                        m_ctr[ui]   = CWEAK;
                     end
                  end
                  li = (lk_pc >> 2) % DEPTH;
                  lt = (lk_pc >> (2 + IDX_W)) % (1 << TAG_W);
                  e.hit   = m_valid[li] && (m_tag[li] == lt);
                  e.taken = e.hit && (m_ctr[li] >= CWEAK);
                  e.tgt   = e.hit ? m_tgt[li] : 32'h0;
               end
               exp_q.push_back(e);
            end
         end
      end
   end

   // Monitor: compare presented outputs against the queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL scoreboard_empty t=%0t: output present, no expectation queued", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (lk_hit !== e.hit || lk_taken !== e.taken ||
                   lk_target !== e.tgt || init_done !== e.done) begin
                  failures++;
                  $display("FAIL lookup t=%0t: got hit=%0d taken=%0d tgt=%h done=%0d, expected hit=%0d taken=%0d tgt=%h done=%0d",
                           $time, lk_hit, lk_taken, lk_target, init_done,
                           e.hit, e.taken, e.tgt, e.done);
               end
            end
         end
      end
   end

   task automatic step(input logic [31:0] lk, input bit ue, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utg, input bit r);
      lk_pc     = lk;
      up_en     = ue;
      up_pc     = upc;
      up_taken  = ut;
      up_target = utg;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = ($urandom_range(0, 2) << (2 + IDX_W)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      return p;
   endfunction

   initial begin
      // Reset and sweep; lookups and updates during the sweep have no effect
      step(32'h0, 0, 32'h0, 0, 32'h0, 1);
      step(32'h0, 0, 32'h0, 0, 32'h0, 1);
      for (int i = 0; i < DEPTH; i++) step(32'h40, 1, 32'h40, 1, 32'h44, 0);
      step(32'h40, 0, 32'h0, 0, 32'h0, 0);

      // Allocation and not-taken miss
      step(32'h0,   1, 32'h100, 1, 32'h200, 0);
      step(32'h100, 1, 32'h104, 0, 32'h0,   0);
      step(32'h104, 0, 32'h0,   0, 32'h0,   0);

      // Saturation both ways
      for (int i = 0; i < 3; i++) step(32'h100, 1, 32'h100, 1, 32'h200, 0);
      step(32'h100, 1, 32'h100, 0, 32'h0, 0);
      step(32'h100, 0, 32'h0,   0, 32'h0, 0);
      for (int i = 0; i < 3; i++) step(32'h100, 1, 32'h100, 0, 32'h0, 0);
      step(32'h100, 0, 32'h0, 0, 32'h0, 0);

      // Tag alias replacement
      step(32'h500, 0, 32'h0,   0, 32'h0,   0);
      step(32'h0,   1, 32'h500, 1, 32'h900, 0);
      step(32'h100, 0, 32'h0,   0, 32'h0,   0);
      step(32'h500, 0, 32'h0,   0, 32'h0,   0);

      // Same-cycle update and lookup (write-first)
      step(32'h180, 1, 32'h180, 1, 32'h300, 0);
      step(32'h180, 0, 32'h0,   0, 32'h0,   0);

      // Reset in the middle of the sweep
      step(32'h0, 1, 32'h100, 1, 32'h200, 0);
      step(32'h100, 0, 32'h0, 0, 32'h0, 1);
      for (int i = 0; i < 7; i++) step(32'h100, 0, 32'h0, 0, 32'h0, 0);
      step(32'h100, 0, 32'h0, 0, 32'h0, 1);
      for (int i = 0; i < DEPTH + 2; i++) step(32'h100, 0, 32'h0, 0, 32'h0, 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] upc, lpc;
         upc = rand_pc();
         lpc = ($urandom_range(0, 3) == 0) ? upc : rand_pc();
         step(lpc, bit'($urandom_range(0, 3) != 0), upc, bit'($urandom_range(0, 1)),
              {$urandom_range(0, 255), 2'b00}, bit'($urandom_range(0, 499) == 0));
      end

      step(32'h0, 0, 32'h0, 0, 32'h0, 0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch prediction unit for the 5-stage core.
- Replaces the untagged 1-bit valid+target BTB with a tagged BTB plus a per-entry N-bit saturating direction counter.
- Looked up by IF PC; prediction registered into ID; trained by every resolved control instruction from WB, not only mispredictions.
- Clears its table after reset with a sweep FSM.

Parameters:
- IDX_W, 10, index bits; table has 2**IDX_W entries; index = pc[2 +: IDX_W].
- TAG_W, 8, tag bits; tag = pc[2+IDX_W +: TAG_W]; IDX_W+TAG_W <= 30.
- CTR_W, 2, direction counter width (>=1); predict taken when counter MSB = 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lk_pc  in  32  IF-stage PC to look up.
- lk_hit  out  1  registered: valid entry with matching tag.
- lk_taken  out  1  registered: lk_hit && counter MSB.
- lk_target  out  32  registered: stored target; 0 when !lk_hit.
- up_en  in  1  WB: a resolved control instruction is retiring (valid && is branch/jump).
- up_pc  in  32  PC of that instruction.
- up_taken  in  1  actual outcome.
- up_target  in  32  actual taken target.
- init_done  out  1  table sweep complete; predictor active.

Behaviour:
- Latency: lk_pc sampled at posedge N; lk_hit/lk_taken/lk_target valid after posedge N (ID-stage timing). No stall input.
- Entry fields: valid, tag[TAG_W], target[32], ctr[CTR_W].
- Lookup hit when entry valid && stored tag == lk_pc tag.
- Update, hit: taken -> ctr = min(ctr+1, 2**CTR_W-1) and target <= up_target; not taken -> ctr = max(ctr-1, 0), target unchanged. Saturation must not wrap.
- Update, miss: taken -> allocate (valid=1, tag, target=up_target, ctr=2**(CTR_W-1), weakly taken), overwriting any aliasing entry. Not taken -> no write.
- Simultaneous lookup and update to the same index in one cycle: write-first. The lookup returns the post-update entry, including a new allocation.
- Updates with up_en=0 have no effect; the PC low 2 bits are ignored.
- FSM states:
  - INIT: counter sweeps idx 0..2**IDX_W-1, one entry per cycle, writing valid=0. Lookups return 0s; updates are dropped. After the last index -> RUN.
  - RUN: normal operation. init_done = 1.
- Reset: rst forces INIT with sweep index 0, init_done=0, lk_hit=0, lk_taken=0, lk_target=0. rst mid-sweep restarts at 0. rst in RUN re-sweeps the whole table.
- init_done rises on the cycle after the final sweep write, exactly 2**IDX_W cycles after rst deasserts.
- Table contents are undefined before the sweep. Outputs must never be X after reset.

Decomposition:
- Shared package `bp_pkg`:
  - constants for ctr weak-taken and max values as functions of CTR_W;
  - entry field widths;
  - state encoding INIT/RUN.
- One sub-module `bp_table`: 1-read/1-write synchronous array of 1+TAG_W+32+CTR_W bits with the write-first bypass.
- The top holds the FSM, index/tag extraction, counter arithmetic and the update read-modify-write. Update reads the entry combinationally from a second read port, or via a one-cycle hazard-checked pipeline; behaviour is as specified above either way.

Test Plan (IDX_W=4, TAG_W=8, CTR_W=2):
- Reset: rst 1 cycle -> init_done=0 for 16 cycles then 1; lookup of 0x40 during init -> hit=0, taken=0, target=0.
- Allocation: up_en, pc=0x100, taken, target=0x200 -> next lookup 0x100 gives hit=1, taken=1 (ctr=2), target=0x200. Not-taken update on an empty 0x104 -> lookup hit=0.
- Saturation: 3 taken updates at 0x100 -> ctr=3; then 1 not-taken -> taken=1; then 2 more not-taken -> ctr=0, hit=1, taken=0; then 1 more not-taken -> ctr stays 0.
- Tag alias: 0x100 allocated; lookup 0x500 (same idx, different tag) -> hit=0. Taken update 0x500 -> 0x900 replaces the entry; lookup 0x100 -> hit=0.
- Bypass: update 0x180 taken to 0x300 in the same cycle as lookup 0x180 -> lookup result hit=1, target=0x300.
- Reset mid-operation: populate 0x100, assert rst at sweep index 7 -> sweep restarts; after 16 cycles lookup 0x100 -> hit=0.
